// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Op codes, FSM states and the funct-to-control decoder.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_NOP   = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  typedef struct packed {
    logic       start;
    logic [2:0] op;
    logic       read_hilo;
  } ctl_t;

  // R-type funct field to unit controls
  function automatic ctl_t decode_funct(
    input logic [5:0] funct
  );
    ctl_t c;
    c = '0;
    c.op = OP_NOP;
    unique case (1'b1)
      funct == FN_MFHI,
      funct == FN_MFLO:  c.read_hilo = 1'b1;
      funct == FN_MTHI:  c = '{1'b1, OP_MTHI, 1'b0};
      funct == FN_MTLO:  c = '{1'b1, OP_MTLO, 1'b0};
      funct == FN_MULT:  c = '{1'b1, OP_MULT, 1'b0};
      funct == FN_MULTU: c = '{1'b1, OP_MULTU, 1'b0};
      funct == FN_DIV:   c = '{1'b1, OP_DIV, 1'b0};
      funct == FN_DIVU:  c = '{1'b1, OP_DIVU, 1'b0};
      default:           c.op = OP_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div.sv
// Iterative restoring unsigned divider core.
// One quotient bit per step; WIDTH steps per divide.
module div_restoring_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   trial;

  assign trial = {rem, quo[WIDTH-1]} - {1'b0, dsr};

  always_ff @(posedge clk) begin
    if (!reset) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle MULT/DIV unit owning the HI/LO registers.
// Sign handling, delayed product, FSM and HI/LO writeback.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             read_hilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             div_by_zero
);

  localparam int CNT_MAX =
    (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
  localparam int CW = $clog2(CNT_MAX);

  state_t state;
  state_t next;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               q_neg;
  logic               r_neg;
  logic               b_zero;
  logic               accept;
  logic               signed_op;
  logic               is_mul;
  logic               is_div;
  logic               load;
  logic               step;

  assign busy   = (state != S_IDLE);
  assign stall  = busy & read_hilo;
  assign accept = start & ~busy;

  assign is_mul = accept &
    ((op == OP_MULT) | (op == OP_MULTU));
  assign is_div = accept &
    ((op == OP_DIV) | (op == OP_DIVU));
  assign signed_op =
    (op == OP_MULT) | (op == OP_DIV);

  assign ext_a = {{WIDTH{signed_op & rs_val[WIDTH-1]}},
                  rs_val};
  assign ext_b = {{WIDTH{signed_op & rt_val[WIDTH-1]}},
                  rt_val};
  assign product = ext_a * ext_b;

  assign abs_a = (signed_op & rs_val[WIDTH-1])
               ? -rs_val : rs_val;
  assign abs_b = (signed_op & rt_val[WIDTH-1])
               ? -rt_val : rt_val;

  div_restoring_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .dividend (abs_a),
    .divisor  (abs_b),
    .quotient (quo),
    .remainder(rem)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    load = 1'b0;
    step = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (is_mul) begin
          next = S_MUL;
        end else if (is_div) begin
          next = S_DIV;
          load = 1'b1;
        end
      end
      S_MUL: begin
        if (cnt == '0) next = S_IDLE;
      end
      S_DIV: begin
        step = 1'b1;
        if (cnt == '0) next = S_FIX;
      end
      S_FIX:   next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      prod        <= '0;
      a_raw       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      b_zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (is_mul) begin
            prod <= product;
            cnt  <= CW'(MUL_LATENCY - 1);
          end
          if (is_div) begin
            cnt    <= CW'(WIDTH - 1);
            a_raw  <= rs_val;
            b_zero <= (rt_val == '0);
            q_neg  <= signed_op &
                      (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
            r_neg  <= signed_op & rs_val[WIDTH-1];
            if (rt_val != '0) div_by_zero <= 1'b0;
          end
          if (accept && op == OP_MTHI) hi <= rs_val;
          if (accept && op == OP_MTLO) lo <= rs_val;
        end
        S_MUL: begin
          if (cnt == '0) begin
            {hi, lo} <= prod;
            done     <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          // zero divisor: LO all ones, HI the raw dividend
          if (b_zero) begin
            lo          <= '1;
            hi          <= a_raw;
            div_by_zero <= 1'b1;
          end else begin
            lo <= q_neg ? -quo : quo;
            hi <= r_neg ? -rem : rem;
          end
          done <= 1'b1;
        end
        default: done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit.
// Directed cases plus randomized ops against an arithmetic model.
module tb_hilo_muldiv_unit;

  localparam int W = 32;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic         read_hilo = 1'b0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         stall;
  logic         div_by_zero;

  hilo_muldiv_unit #(
    .WIDTH(W),
    .MUL_LATENCY(L)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .read_hilo  (read_hilo),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .stall      (stall),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dbz = 1'b0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("result_hi", hi, e.hi);
        chk("result_lo", lo, e.lo);
        chk("result_dbz", div_by_zero, e.dbz);
      end
    end
  end

  function automatic exp_t model(input logic [2:0] o,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    longint      sa;
    longint      sb_;
    longint      ua;
    longint      ub;
    sa  = $signed(a);
    sb_ = $signed(b);
    ua  = a;
    ub  = b;
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.dbz = m_dbz;
    if (o == 3'd0 || o == 3'd1) begin
      p = (o == 3'd0) ? sa * sb_ : ua * ub;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.lo  = '1;
      e.hi  = a;
      e.dbz = 1'b1;
    end else begin
      q = (o == 3'd2) ? sa / sb_ : ua / ub;
      r = (o == 3'd2) ? sa % sb_ : ua % ub;
      e.lo  = q[31:0];
      e.hi  = r[31:0];
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run(input logic [2:0] o,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input logic rh,
                     input string name);
    exp_t         e;
    logic [W-1:0] ohi;
    logic [W-1:0] olo;
    int           n;
    int           bad;
    wait_idle();
    op = o; rs_val = a; rt_val = b;
    read_hilo = rh; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (o <= 3'd3) begin
      ohi = m_hi; olo = m_lo;
      e = model(o, a, b);
      sb.push_back(e);
      m_hi = e.hi; m_lo = e.lo; m_dbz = e.dbz;
      n = 0; bad = 0;
      while (busy && n < 200) begin
        if (stall !== rh) bad++;
        if (hi !== ohi || lo !== olo) bad++;
        @(posedge clk); #1;
        n++;
      end
      chk({name, "_latency"}, n,
          (o <= 3'd1) ? L : W + 1);
      chk({name, "_busy_stall_hold"}, bad, 0);
      chk({name, "_stall_after"}, stall, 0);
    end else if (o == 3'd4) begin
      m_hi = a;
      chk({name, "_hi"}, hi, m_hi);
    end else if (o == 3'd5) begin
      m_lo = a;
      chk({name, "_lo"}, lo, m_lo);
    end else begin
      chk({name, "_nop"}, {hi, lo}, {m_hi, m_lo});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=1 required=0");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
    int           n;

    read_hilo = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_stall", stall, 0);
    reset = 1'b1;
    read_hilo = 1'b0;

    run(3'd0, 32'hFFFFFFFE, 32'h3, 1'b0, "mult");
    run(3'd1, 32'hFFFFFFFE, 32'h3, 1'b0, "multu");
    run(3'd2, 32'hFFFFFFF9, 32'h2, 1'b1, "div_neg");
    run(3'd3, 32'd100, 32'd7, 1'b0, "divu");
    run(3'd2, 32'h12345678, 32'h0, 1'b0, "div_zero");
    chk("dbz_sticky", div_by_zero, 1);
    run(3'd3, 32'd10, 32'd3, 1'b0, "divu_clear");
    chk("dbz_cleared", div_by_zero, 0);
    run(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");

    wait_idle();
    op = 3'd3; rs_val = 32'd1000; rt_val = 32'd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = model(3'd3, 32'd1000, 32'd10);
    sb.push_back(e);
    repeat (3) @(posedge clk);
    #1;
    op = 3'd4; rs_val = 32'hDEADBEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mthi_busy_ignored", hi, m_hi);
    m_hi = e.hi; m_lo = e.lo; m_dbz = e.dbz;
    wait_idle();
    run(3'd5, 32'hCAFEBABE, 32'h0, 1'b0, "mtlo");
    run(3'd4, 32'h0BADF00D, 32'h0, 1'b0, "mthi");

    wait_idle();
    op = 3'd2; rs_val = 32'h7777; rt_val = 32'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dbz", div_by_zero, 0);
    sb.delete();
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    reset = 1'b1;
    run(3'd0, 32'd3, 32'd5, 1'b0, "mult_after_rst");

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      n = $urandom_range(0, 9);
      if (n == 0) b = '0;
      else if (n == 1) b = 32'($urandom_range(1, 15));
      else if (n == 2) b = 32'hFFFFFFFF;
      else b = $urandom;
      if (n == 2 && $urandom_range(0, 1) == 1)
        a = 32'h80000000;
      run(o, a, b, 1'($urandom_range(0, 1)), "rand");
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
